// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// start-glitch rejection, parity/framing/overrun flags and a valid/ack handshake.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    input  logic                 RX_ACK,
    output logic [DATA_BITS-1:0] DQ,
    output logic                 RX_READY,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Start vote fires one cycle after the centre so the window is centre-1..centre+1.
    localparam logic [CW-1:0] C_START_EVAL = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_LAST       = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    B_DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_STOP_LAST  = 4'(STOP_BITS - 1);

    logic [2:0]           r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_hist;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_dq;
    logic                 r_ready;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_ovr;

    logic w_vote;
    logic w_tick;
    logic w_par_xor;
    logic w_perr;

    assign w_vote    = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
    assign w_tick    = (r_clk_cnt == C_LAST);
    assign w_par_xor = ^{r_shift, r_par_bit};
    assign w_perr    = (PARITY == 1) ? ~w_par_xor : ((PARITY == 2) ? w_par_xor : 1'b0);

    assign DQ         = r_dq;
    assign RX_READY   = r_ready;
    assign PARITY_ERR = r_perr_out;
    assign FRAME_ERR  = r_ferr_out;
    assign OVERRUN    = r_ovr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_hist     <= '1;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
            r_dq       <= '0;
            r_ready    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[0], r_sync2};

            if (r_ready && RX_ACK) begin
                r_ready <= 1'b0;
                r_ovr   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                    r_ferr    <= 1'b0;
                    // The detect cycle is the first low sample, so counting starts at 1.
                    if (r_hist[0] && !r_sync2) begin
                        r_state   <= S_START;
                        r_clk_cnt <= CW'(1);
                    end else begin
                        r_clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == C_START_EVAL) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_vote ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == B_DATA_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= w_vote;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bit_cnt == B_STOP_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_dq       <= r_shift;
                    r_perr_out <= w_perr;
                    r_ferr_out <= r_ferr;
                    r_ready    <= 1'b1;
                    // Overrides the handshake clear above: an ack in this cycle keeps OVERRUN low.
                    r_ovr      <= r_ready & ~RX_ACK;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven from one clock, frames
// built as bit lists and checked against an ideal frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] rxd;
    logic [2:0] ack;
    logic [7:0] dq_a;
    logic [7:0] dq_b;
    logic [6:0] dq_c;
    logic [2:0] rdy;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] ovr;

    int total = 0;
    int bad = 0;
    int meas_lat = 0;

    int cfg_db[3]  = '{8, 8, 7};
    int cfg_par[3] = '{0, 2, 1};
    int cfg_sb[3]  = '{1, 1, 2};

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .CLK(clk), .RST(rst[0]), .RXD(rxd[0]), .RX_ACK(ack[0]), .DQ(dq_a),
        .RX_READY(rdy[0]), .PARITY_ERR(perr[0]), .FRAME_ERR(ferr[0]), .OVERRUN(ovr[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .CLK(clk), .RST(rst[1]), .RXD(rxd[1]), .RX_ACK(ack[1]), .DQ(dq_b),
        .RX_READY(rdy[1]), .PARITY_ERR(perr[1]), .FRAME_ERR(ferr[1]), .OVERRUN(ovr[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .CLK(clk), .RST(rst[2]), .RXD(rxd[2]), .RX_ACK(ack[2]), .DQ(dq_c),
        .RX_READY(rdy[2]), .PARITY_ERR(perr[2]), .FRAME_ERR(ferr[2]), .OVERRUN(ovr[2]));

    function automatic logic [8:0] dq_of(input int k);
        case (k)
            0:       return {1'b0, dq_a};
            1:       return {1'b0, dq_b};
            default: return {2'b00, dq_c};
        endcase
    endfunction

    function automatic logic [8:0] mask_of(input int k);
        return 9'((1 << cfg_db[k]) - 1);
    endfunction

    // Parity bit as it appears on the line: correct for the mode, optionally inverted.
    function automatic logic line_pb(input int k, input logic [8:0] data, input logic flip);
        logic pb;
        pb = (cfg_par[k] == 2) ? ^data : ~^data;
        return pb ^ flip;
    endfunction

    function automatic logic exp_perr(input int k, input logic [8:0] data, input logic flip);
        logic x;
        x = (^data) ^ line_pb(k, data, flip);
        if (cfg_par[k] == 1) return ~x;
        if (cfg_par[k] == 2) return x;
        return 1'b0;
    endfunction

    function automatic logic exp_ferr(input int k, input logic [1:0] stops);
        return (cfg_sb[k] == 2) ? ~&stops : ~stops[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int k, input logic [8:0] data, input logic flip,
                              input logic [1:0] stops);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < cfg_db[k]; i++) q.push_back(data[i]);
        if (cfg_par[k] != 0) q.push_back(line_pb(k, data, flip));
        for (int i = 0; i < cfg_sb[k]; i++) q.push_back(stops[i]);
        foreach (q[i]) begin
            rxd[k] = q[i];
            repeat (CPB) tick();
        end
        rxd[k] = 1'b1;
    endtask

    // Sends one frame, checks the committed result, acknowledges and checks the clear.
    task automatic rx_expect(input string tag, input int k, input logic [8:0] data_in,
                             input logic flip, input logic [1:0] stops);
        logic [8:0] data;
        int n;
        data = data_in & mask_of(k);
        send_frame(k, data, flip, stops);
        n = 0;
        while (rdy[k] !== 1'b1 && n < 4 * CPB) begin
            tick();
            n++;
        end
        total++;
        if (rdy[k] !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_timeout k=%0d got=%b want=1", tag, k, rdy[k]);
        end
        total++;
        if (dq_of(k) !== data) begin
            bad++;
            $display("FAIL %s dq k=%0d got=%h want=%h", tag, k, dq_of(k), data);
        end
        total++;
        if (perr[k] !== exp_perr(k, data, flip)) begin
            bad++;
            $display("FAIL %s parity_err k=%0d got=%b want=%b", tag, k, perr[k], exp_perr(k, data, flip));
        end
        total++;
        if (ferr[k] !== exp_ferr(k, stops)) begin
            bad++;
            $display("FAIL %s frame_err k=%0d got=%b want=%b", tag, k, ferr[k], exp_ferr(k, stops));
        end
        total++;
        if (ovr[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s overrun k=%0d got=%b want=0", tag, k, ovr[k]);
        end
        ack[k] = 1'b1;
        tick();
        ack[k] = 1'b0;
        total++;
        if (rdy[k] !== 1'b0 || dq_of(k) !== data) begin
            bad++;
            $display("FAIL %s after_ack k=%0d got rdy=%b dq=%h want rdy=0 dq=%h",
                     tag, k, rdy[k], dq_of(k), data);
        end
        repeat (2 * CPB) tick();
    endtask

    task automatic test_reset();
        rst = '1;
        rxd = '1;
        ack = '0;
        repeat (3) tick();
        rst = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dq_of(k) !== 9'd0 || rdy[k] !== 1'b0 || perr[k] !== 1'b0 ||
                ferr[k] !== 1'b0 || ovr[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state k=%0d got dq=%h rdy=%b pe=%b fe=%b ov=%b want all 0",
                         k, dq_of(k), rdy[k], perr[k], ferr[k], ovr[k]);
            end
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        tick();
        total++;
        if (rdy[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack got rdy=%b ov=%b want 0 0", rdy[0], ovr[0]);
        end
    endtask

    task automatic test_basic();
        int n;
        int nbits;
        n = 0;
        nbits = cfg_db[0] + cfg_sb[0];
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11);
            begin
                while (rdy[0] !== 1'b1 && n < 400) begin
                    tick();
                    n++;
                end
            end
        join
        meas_lat = n;
        total++;
        if (n < HALF + 3 + nbits * CPB || n > HALF + 5 + nbits * CPB) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d..%0d", n, HALF + 3 + nbits * CPB, HALF + 5 + nbits * CPB);
        end
        total++;
        if (dq_a !== 8'hA5 || perr[0] !== 1'b0 || ferr[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_frame got dq=%h pe=%b fe=%b ov=%b want a5 0 0 0", dq_a, perr[0], ferr[0], ovr[0]);
        end
        repeat (3) tick();
        total++;
        if (rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL ready_hold got=%b want=1", rdy[0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        total++;
        if (rdy[0] !== 1'b0 || dq_a !== 8'hA5) begin
            bad++;
            $display("FAIL basic_ack got rdy=%b dq=%h want 0 a5", rdy[0], dq_a);
        end
        repeat (2 * CPB) tick();
    endtask

    task automatic test_parity();
        rx_expect("even_ok", 1, 9'h003, 1'b0, 2'b11);
        rx_expect("even_bad", 1, 9'h003, 1'b1, 2'b11);
        rx_expect("odd_ok", 2, 9'h055, 1'b0, 2'b11);
        rx_expect("odd_bad", 2, 9'h055, 1'b1, 2'b11);
    endtask

    task automatic test_framing();
        rx_expect("stop_low", 0, 9'h055, 1'b0, 2'b00);
        rx_expect("after_ferr", 0, 9'h00F, 1'b0, 2'b11);
        rx_expect("stop2_low", 2, 9'h012, 1'b0, 2'b01);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 9'h011, 1'b0, 2'b11);
        send_frame(0, 9'h022, 1'b0, 2'b11);
        repeat (2) tick();
        total++;
        if (dq_a !== 8'h22 || rdy[0] !== 1'b1 || ovr[0] !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set got dq=%h rdy=%b ov=%b want 22 1 1", dq_a, rdy[0], ovr[0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        total++;
        if (rdy[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got rdy=%b ov=%b want 0 0", rdy[0], ovr[0]);
        end
        repeat (2 * CPB) tick();

        send_frame(0, 9'h011, 1'b0, 2'b11);
        fork
            send_frame(0, 9'h022, 1'b0, 2'b11);
            begin
                repeat (meas_lat - 1) tick();
                total++;
                if (dq_a !== 8'h11 || rdy[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL pre_commit got dq=%h rdy=%b want 11 1", dq_a, rdy[0]);
                end
                ack[0] = 1'b1;
                tick();
                ack[0] = 1'b0;
            end
        join
        total++;
        if (dq_a !== 8'h22 || rdy[0] !== 1'b1 || ovr[0] !== 1'b0) begin
            bad++;
            $display("FAIL ack_at_commit got dq=%h rdy=%b ov=%b want 22 1 0", dq_a, rdy[0], ovr[0]);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        repeat (2 * CPB) tick();
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        rxd[0] = 1'b0;
        repeat (4) tick();
        rxd[0] = 1'b1;
        repeat (12 * CPB) begin
            tick();
            if (rdy[0] !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL glitch got ready_cycles=%0d want=0", seen);
        end
        rx_expect("post_glitch", 0, 9'h03C, 1'b0, 2'b11);
    endtask

    task automatic test_reset_midframe();
        int seen;
        seen = 0;
        fork
            send_frame(0, 9'h0F5, 1'b0, 2'b11);
            begin
                repeat (5 * CPB + HALF) tick();
                rst[0] = 1'b1;
                tick();
                rst[0] = 1'b0;
                total++;
                if (dq_a !== 8'h00 || rdy[0] !== 1'b0 || perr[0] !== 1'b0 ||
                    ferr[0] !== 1'b0 || ovr[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL midframe_reset got dq=%h rdy=%b fe=%b ov=%b want all 0",
                             dq_a, rdy[0], ferr[0], ovr[0]);
                end
            end
        join
        repeat (2 * CPB) begin
            tick();
            if (rdy[0] !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abandoned_frame got ready_cycles=%0d want=0", seen);
        end
        rx_expect("after_reset", 0, 9'h0C3, 1'b0, 2'b11);
        rx_expect("seven_bit", 2, 9'h07F, 1'b0, 2'b11);
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic       f;
        logic [1:0] s;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                d = 9'($urandom);
                f = (cfg_par[k] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                rx_expect("random", k, d, f, s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
